// File: rtl/vsc_pkg.sv
// Shared types and defaults for the vector sweep controller and its result accumulator.
package vsc_pkg;

  localparam int unsigned N_IN_DEFAULT = 8;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StApply = 3'd1,
    StWait  = 3'd2,
    StCheck = 3'd3,
    StDone  = 3'd4
  } state_e;

endpackage

// File: rtl/vsc_result_acc.sv
// Per-sweep result accumulator: mismatch count, ones count and first failing vector.
module vsc_result_acc
  import vsc_pkg::*;
#(
  parameter int unsigned N_IN = N_IN_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            sample_i,
  input  logic            x_dut_i,
  input  logic            x_ref_i,
  input  logic [N_IN-1:0] vec_i,
  output logic [N_IN:0]   err_cnt_o,
  output logic [N_IN:0]   ones_cnt_o,
  output logic [N_IN-1:0] first_fail_o,
  output logic            fail_valid_o
);

  logic [N_IN:0]   err_q, err_d;
  logic [N_IN:0]   ones_q, ones_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic            fv_q, fv_d;
  logic            mismatch;

  assign mismatch = x_dut_i ^ x_ref_i;

  always_comb begin
    err_d  = err_q;
    ones_d = ones_q;
    ff_d   = ff_q;
    fv_d   = fv_q;
    if (clear_i) begin
      err_d  = '0;
      ones_d = '0;
      ff_d   = '0;
      fv_d   = 1'b0;
    end else if (sample_i) begin
      if (mismatch) begin
        err_d = err_q + 1'b1;
        // Only the earliest failure in the sweep is kept.
        if (!fv_q) begin
          ff_d = vec_i;
          fv_d = 1'b1;
        end
      end
      if (x_dut_i) begin
        ones_d = ones_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q  <= '0;
      ones_q <= '0;
      ff_q   <= '0;
      fv_q   <= 1'b0;
    end else begin
      err_q  <= err_d;
      ones_q <= ones_d;
      ff_q   <= ff_d;
      fv_q   <= fv_d;
    end
  end

  assign err_cnt_o    = err_q;
  assign ones_cnt_o   = ones_q;
  assign first_fail_o = ff_q;
  assign fail_valid_o = fv_q;

endmodule

// File: rtl/vector_sweep_controller.sv
// Steps a stimulus vector through a range, waits a settle time per vector and compares
// the block-under-test output against a golden model.
module vector_sweep_controller
  import vsc_pkg::*;
#(
  parameter int unsigned N_IN     = N_IN_DEFAULT,
  parameter int unsigned SETTLE_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [N_IN-1:0]     first_vec,
  input  logic [N_IN-1:0]     last_vec,
  input  logic [SETTLE_W-1:0] settle,
  output logic [N_IN-1:0]     vec,
  input  logic                x_dut,
  input  logic                x_ref,
  output logic                busy,
  output logic                done,
  output logic [N_IN:0]       err_cnt,
  output logic [N_IN:0]       ones_cnt,
  output logic [N_IN-1:0]     first_fail,
  output logic                fail_valid
);

  state_e              state_q, state_d;
  logic [N_IN-1:0]     vec_q, vec_d;
  logic [N_IN-1:0]     last_q, last_d;
  logic [SETTLE_W-1:0] wait_q, wait_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                acc_clear;
  logic                acc_sample;

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    last_d     = last_q;
    wait_d     = wait_q;
    acc_clear  = 1'b0;
    acc_sample = 1'b0;
    if (abort) begin
      state_d = StIdle;
      vec_d   = '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d   = StApply;
            vec_d     = first_vec;
            last_d    = last_vec;
            acc_clear = 1'b1;
          end
        end
        StApply: begin
          // A settle of zero behaves as one wait cycle.
          wait_d  = (settle == '0) ? '0 : settle - 1'b1;
          state_d = StWait;
        end
        StWait: begin
          if (wait_q == '0) begin
            state_d = StCheck;
          end else begin
            wait_d = wait_q - 1'b1;
          end
        end
        StCheck: begin
          acc_sample = 1'b1;
          if (vec_q == last_q) begin
            state_d = StDone;
          end else begin
            vec_d   = vec_q + 1'b1;
            state_d = StApply;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
    busy_d = (state_d == StApply) || (state_d == StWait) || (state_d == StCheck);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      vec_q   <= '0;
      last_q  <= '0;
      wait_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      last_q  <= last_d;
      wait_q  <= wait_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  vsc_result_acc #(
    .N_IN(N_IN)
  ) u_result_acc (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (acc_clear),
    .sample_i    (acc_sample),
    .x_dut_i     (x_dut),
    .x_ref_i     (x_ref),
    .vec_i       (vec_q),
    .err_cnt_o   (err_cnt),
    .ones_cnt_o  (ones_cnt),
    .first_fail_o(first_fail),
    .fail_valid_o(fail_valid)
  );

  assign vec  = vec_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_vector_sweep_controller.sv
// Scoreboard bench: the driver queues expected vector sequences and end-of-sweep results,
// a negedge monitor pops and compares them as the controller presents them.
module tb_vector_sweep_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] first_vec;
  logic [7:0] last_vec;
  logic [3:0] settle;
  logic [7:0] vec;
  logic       x_dut;
  logic       x_ref;
  logic       busy;
  logic       done;
  logic [8:0] err_cnt;
  logic [8:0] ones_cnt;
  logic [7:0] first_fail;
  logic       fail_valid;

  bit fault [256];

  // Golden logic block: X = (A & B) | (G & H)
  function automatic logic ref_fn(input logic [7:0] v);
    return (v[7] & v[6]) | (v[1] & v[0]);
  endfunction

  assign x_ref = ref_fn(vec);
  assign x_dut = ref_fn(vec) ^ fault[vec];

  vector_sweep_controller #(
    .N_IN    (8),
    .SETTLE_W(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .first_vec (first_vec),
    .last_vec  (last_vec),
    .settle    (settle),
    .vec       (vec),
    .x_dut     (x_dut),
    .x_ref     (x_ref),
    .busy      (busy),
    .done      (done),
    .err_cnt   (err_cnt),
    .ones_cnt  (ones_cnt),
    .first_fail(first_fail),
    .fail_valid(fail_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cycles;
    logic       done;
    logic [7:0] vec;
    logic [8:0] err;
    logic [8:0] ones;
    logic [7:0] ff;
    logic       fv;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_vecs[$];
  int         checks = 0;
  int         failures = 0;
  int         ends_seen = 0;
  int         start_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Model of one sweep: the vectors it applies and the counters it should leave behind.
  task automatic expect_sweep(input logic [7:0] f, input int n_applied, input int n_checked,
                              input int cycles, input bit is_done, input logic [7:0] end_vec,
                              input bit zeroed);
    exp_t       e;
    logic [7:0] v;
    logic       xd;
    e.err  = '0;
    e.ones = '0;
    e.ff   = '0;
    e.fv   = 1'b0;
    v = f;
    for (int i = 0; i < n_applied; i++) begin
      exp_vecs.push_back(v);
      if (i < n_checked) begin
        xd = ref_fn(v) ^ fault[v];
        if (xd != ref_fn(v)) begin
          e.err = e.err + 1'b1;
          if (!e.fv) begin
            e.ff = v;
            e.fv = 1'b1;
          end
        end
        if (xd) e.ones = e.ones + 1'b1;
      end
      v = v + 1'b1;
    end
    if (zeroed) begin
      e.err  = '0;
      e.ones = '0;
      e.ff   = '0;
      e.fv   = 1'b0;
    end
    e.cycles = cycles;
    e.done   = is_done;
    e.vec    = end_vec;
    exp_q.push_back(e);
  endtask

  // Monitor: a new vector is captured when busy rises or vec moves; a sweep ends when busy falls.
  exp_t       mon_e;
  logic [7:0] mon_v;
  logic       busy_prev = 1'b0;
  logic [7:0] vec_last = '0;

  always @(negedge clk) begin
    if (busy === 1'b1 && (busy_prev !== 1'b1 || vec !== vec_last)) begin
      if (exp_vecs.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL vec_seq: got %0h expected no further vector", vec);
      end else begin
        mon_v = exp_vecs.pop_front();
        check("vec_seq", 32'(vec), 32'(mon_v));
      end
    end
    if (busy_prev === 1'b1 && busy !== 1'b1) begin
      ends_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sweep_end: got unexpected end of sweep expected none");
      end else begin
        mon_e = exp_q.pop_front();
        check("cycles", 32'(cyc - start_cyc), 32'(mon_e.cycles));
        check("done", 32'(done), 32'(mon_e.done));
        check("end_vec", 32'(vec), 32'(mon_e.vec));
        check("err_cnt", 32'(err_cnt), 32'(mon_e.err));
        check("ones_cnt", 32'(ones_cnt), 32'(mon_e.ones));
        check("first_fail", 32'(first_fail), 32'(mon_e.ff));
        check("fail_valid", 32'(fail_valid), 32'(mon_e.fv));
        check("vecs_left", 32'(exp_vecs.size()), 32'd0);
      end
    end
    busy_prev = busy;
    vec_last  = vec;
  end

  task automatic do_start(input logic [7:0] f, input logic [7:0] l, input logic [3:0] s);
    @(posedge clk);
    #1;
    first_vec = f;
    last_vec  = l;
    settle    = s;
    start     = 1'b1;
    start_cyc = cyc + 1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input int n, input int budget);
    int k;
    k = 0;
    while (ends_seen < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    checks++;
    if (ends_seen < n) begin
      failures++;
      $display("FAIL sweep_timeout: got %0d sweep ends expected %0d", ends_seen, n);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vec"}, 32'(vec), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err_cnt), 32'd0);
    check({tag, "_ones"}, 32'(ones_cnt), 32'd0);
    check({tag, "_ff"}, 32'(first_fail), 32'd0);
    check({tag, "_fv"}, 32'(fail_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    first_vec = '0;
    last_vec  = '0;
    settle    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all_zero("reset");

    // 1: exhaustive, no faults
    expect_sweep(8'h00, 256, 256, 768, 1'b1, 8'hFF, 1'b0);
    do_start(8'h00, 8'hFF, 4'd1);
    wait_end(1, 2000);
    check("t1_ones_hand", 32'(ones_cnt), 32'd112);
    check("t1_fv_hand", 32'(fail_valid), 32'd0);

    // 2: faults at F0 and F5
    fault[8'hF0] = 1'b1;
    fault[8'hF5] = 1'b1;
    expect_sweep(8'h00, 256, 256, 768, 1'b1, 8'hFF, 1'b0);
    do_start(8'h00, 8'hFF, 4'd1);
    wait_end(2, 2000);
    check("t2_err_hand", 32'(err_cnt), 32'd2);
    check("t2_ff_hand", 32'(first_fail), 32'hF0);
    check("t2_ones_hand", 32'(ones_cnt), 32'd110);
    fault[8'hF0] = 1'b0;
    fault[8'hF5] = 1'b0;

    // 3: wrap-around range
    expect_sweep(8'hFE, 4, 4, 20, 1'b1, 8'h01, 1'b0);
    do_start(8'hFE, 8'h01, 4'd3);
    wait_end(3, 200);
    check("t3_ones_hand", 32'(ones_cnt), 32'd2);

    // 4: single vector, settle 0
    expect_sweep(8'hA5, 1, 1, 3, 1'b1, 8'hA5, 1'b0);
    do_start(8'hA5, 8'hA5, 4'd0);
    wait_end(4, 200);
    repeat (3) @(posedge clk);
    #1;
    check("t4_vec_held", 32'(vec), 32'hA5);
    check("t4_done_held", 32'(done), 32'd1);

    // 5: abort in WAIT of vector 0x0A, stray start mid-sweep
    fault[8'h05] = 1'b1;
    expect_sweep(8'h00, 11, 10, 42, 1'b0, 8'h00, 1'b0);
    do_start(8'h00, 8'hFF, 4'd2);
    repeat (10) @(posedge clk);
    #1;
    first_vec = 8'h80;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    wait_end(5, 200);
    check("t5_err_hand", 32'(err_cnt), 32'd1);
    check("t5_ff_hand", 32'(first_fail), 32'h05);
    check("t5_ones_hand", 32'(ones_cnt), 32'd3);
    fault[8'h05] = 1'b0;

    // 6: reset mid-sweep, then a clean sweep with one fault
    expect_sweep(8'h00, 34, 33, 101, 1'b0, 8'h00, 1'b1);
    do_start(8'h00, 8'hFF, 4'd1);
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_end(6, 200);
    check_all_zero("t6_reset");
    fault[8'h12] = 1'b1;
    expect_sweep(8'h10, 17, 17, 68, 1'b1, 8'h20, 1'b0);
    do_start(8'h10, 8'h20, 4'd2);
    wait_end(7, 400);
    check("t6_err_hand", 32'(err_cnt), 32'd1);
    check("t6_ff_hand", 32'(first_fail), 32'h12);
    fault[8'h12] = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
